// File: rtl/maze_player_ctrl.sv
// Maze player controller: owns the maze RAM read port once generation is done and moves a
// player token in response to debounced direction buttons, checking each move against the
// maze (1 = wall, 0 = floor). Reports position, accepted move count and exit arrival.
// Optional build macro WALL_BUMP_EN adds a one-clock 'bump' pulse on every rejected move.
module maze_player_ctrl #(
  parameter int unsigned WIDTH   = 30,
  parameter int unsigned HEIGHT  = 40,
  parameter int unsigned START_X = 0,
  parameter int unsigned START_Y = 0,
  parameter int unsigned EXIT_X  = 28,
  parameter int unsigned EXIT_Y  = 39
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        gen_end,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  output logic [10:0] maze_address,
  input  logic        maze_address_data,
  output logic [5:0]  player_x,
  output logic [5:0]  player_y,
  output logic [15:0] move_count,
  output logic        at_exit,
`ifdef WALL_BUMP_EN
  output logic        bump,
`endif
  output logic        busy
);

  localparam logic [5:0] XMax   = 6'(WIDTH - 1);
  localparam logic [5:0] YMax   = 6'(HEIGHT - 1);
  localparam logic [5:0] XStart = 6'(START_X);
  localparam logic [5:0] YStart = 6'(START_Y);
  localparam logic [5:0] XExit  = 6'(EXIT_X);
  localparam logic [5:0] YExit  = 6'(EXIT_Y);

  typedef enum logic [2:0] {
    StIdle,
    StReady,
    StIssue,
    StWait,
    StCheck,
    StDone
  } state_e;

  // Row-major RAM address of a tile; the product fits in 11 bits for the supported sizes.
  function automatic logic [10:0] addr_of(input logic [5:0] x, input logic [5:0] y);
    return 11'(WIDTH) * {5'd0, y} + {5'd0, x};
  endfunction

  state_e      state_q, state_d;
  logic [5:0]  x_q, x_d, y_q, y_d;
  logic [5:0]  tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
  logic [10:0] tgt_addr_q, tgt_addr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  btn_prev_q, btn_now, btn_rise;
  logic        busy_q, busy_d;
  logic        at_exit_q, at_exit_d;
  logic        bump_q, bump_d;

  // Buttons packed as {up, down, left, right}; the bit order sets the priority.
  assign btn_now  = {btn_up, btn_down, btn_left, btn_right};
  assign btn_rise = btn_now & ~btn_prev_q;

  // Next-state logic: edge-triggered move requests, RAM lookup sequencing and move commit.
  always_comb begin
    logic [5:0] nx, ny;
    logic       ok;
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    cnt_d      = cnt_q;
    tgt_x_d    = tgt_x_q;
    tgt_y_d    = tgt_y_q;
    tgt_addr_d = tgt_addr_q;
    bump_d     = 1'b0;
    nx         = x_q;
    ny         = y_q;
    ok         = 1'b1;

    if (!gen_end) begin
      // Maze invalid: abandon everything, including any lookup in flight.
      state_d = StIdle;
      x_d     = XStart;
      y_d     = YStart;
      cnt_d   = 16'd0;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StReady;
        StReady: begin
          if (btn_rise != 4'b0000) begin
            // Bounds are tested before stepping so the coordinates never wrap.
            if (btn_rise[3]) begin
              if (y_q == 6'd0) ok = 1'b0;
              else             ny = y_q - 6'd1;
            end else if (btn_rise[2]) begin
              if (y_q >= YMax) ok = 1'b0;
              else             ny = y_q + 6'd1;
            end else if (btn_rise[1]) begin
              if (x_q == 6'd0) ok = 1'b0;
              else             nx = x_q - 6'd1;
            end else begin
              if (x_q >= XMax) ok = 1'b0;
              else             nx = x_q + 6'd1;
            end
            if (ok) begin
              tgt_x_d    = nx;
              tgt_y_d    = ny;
              tgt_addr_d = addr_of(nx, ny);
              state_d    = StIssue;
            end else begin
              bump_d = 1'b1;
            end
          end
        end
        StIssue: state_d = StWait;
        StWait:  state_d = StCheck;
        StCheck: begin
          if (maze_address_data) begin
            bump_d = 1'b1;
          end else begin
            x_d = tgt_x_q;
            y_d = tgt_y_q;
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          end
          state_d = (x_d == XExit && y_d == YExit) ? StDone : StReady;
        end
        StDone:  state_d = StDone;
        default: state_d = StIdle;
      endcase
    end

    busy_d    = (state_d == StIssue) || (state_d == StWait) || (state_d == StCheck);
    at_exit_d = (state_d == StDone);
  end

  // State and registered outputs; button history is tracked in every state so that a
  // button held through a lookup does not register as a fresh edge afterwards.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      x_q        <= XStart;
      y_q        <= YStart;
      cnt_q      <= 16'd0;
      tgt_x_q    <= 6'd0;
      tgt_y_q    <= 6'd0;
      tgt_addr_q <= 11'd0;
      btn_prev_q <= 4'b0000;
      busy_q     <= 1'b0;
      at_exit_q  <= 1'b0;
      bump_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      cnt_q      <= cnt_d;
      tgt_x_q    <= tgt_x_d;
      tgt_y_q    <= tgt_y_d;
      tgt_addr_q <= tgt_addr_d;
      btn_prev_q <= btn_now;
      busy_q     <= busy_d;
      at_exit_q  <= at_exit_d;
      bump_q     <= bump_d;
    end
  end

  // Address mux: the lookup target while busy, otherwise the player's own tile.
  always_comb begin
    maze_address = busy_q ? tgt_addr_q : addr_of(x_q, y_q);
  end

  assign player_x   = x_q;
  assign player_y   = y_q;
  assign move_count = cnt_q;
  assign at_exit    = at_exit_q;
  assign busy       = busy_q;

`ifdef WALL_BUMP_EN
  assign bump = bump_q;
`else
  logic unused_bump;
  assign unused_bump = bump_q;
`endif

endmodule

// File: tb/tb_maze_player_ctrl.sv
// Randomized bench for maze_player_ctrl against a behavioural model of the player rules,
// with a two-clock-latency RAM model on the maze read port.
module tb_maze_player_ctrl;

  localparam int W  = 30;
  localparam int H  = 40;
  localparam int EX = 28;
  localparam int EY = 39;

  logic        clock = 1'b0;
  logic        reset;
  logic        gen_end;
  logic        btn_up, btn_down, btn_left, btn_right;
  logic [10:0] maze_address;
  logic        maze_address_data;
  logic [5:0]  player_x, player_y;
  logic [15:0] move_count;
  logic        at_exit, busy;
`ifdef WALL_BUMP_EN
  logic        bump;
`endif

  int n_vec = 0;
  int n_err = 0;

  maze_player_ctrl dut (
    .clock             (clock),
    .reset             (reset),
    .gen_end           (gen_end),
    .btn_up            (btn_up),
    .btn_down          (btn_down),
    .btn_left          (btn_left),
    .btn_right         (btn_right),
    .maze_address      (maze_address),
    .maze_address_data (maze_address_data),
    .player_x          (player_x),
    .player_y          (player_y),
    .move_count        (move_count),
    .at_exit           (at_exit),
`ifdef WALL_BUMP_EN
    .bump              (bump),
`endif
    .busy              (busy)
  );

  always #5 clock = ~clock;

  // RAM: address registered, then data registered -> valid 2 clocks after address.
  bit         maze [W*H];
  logic [10:0] ram_a1 = 11'd0;
  always @(posedge clock) begin
    ram_a1            <= maze_address;
    maze_address_data <= maze[ram_a1];
  end

  // Reference model state.
  int       m_x, m_y, m_cnt, m_pend, t_x, t_y;
  bit       m_exit, m_armed, m_bump;
  bit [3:0] m_prev;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 0; m_y = 0; m_cnt = 0; m_pend = 0; t_x = 0; t_y = 0;
    m_exit = 0; m_armed = 0; m_bump = 0; m_prev = 4'b0000;
  endtask

  // One clock of the player rules, from the inputs present at the edge.
  task automatic model_step();
    bit [3:0] btn, rise;
    int dx, dy, nx, ny;
    btn = {btn_up, btn_down, btn_left, btn_right};
    m_bump = 0;
    if (reset) begin
      model_reset();
      return;
    end
    if (!gen_end) begin
      m_x = 0; m_y = 0; m_cnt = 0; m_pend = 0; m_exit = 0; m_armed = 0;
    end else if (!m_armed) begin
      m_armed = 1;
    end else if (m_pend > 0) begin
      m_pend--;
      if (m_pend == 0) begin
        if (maze[t_y*W + t_x]) m_bump = 1;
        else begin
          m_x = t_x; m_y = t_y;
          if (m_cnt < 65535) m_cnt++;
        end
        if (m_x == EX && m_y == EY) m_exit = 1;
      end
    end else if (!m_exit) begin
      rise = btn & ~m_prev;
      dx = 0; dy = 0;
      if (rise[3])      dy = -1;
      else if (rise[2]) dy = 1;
      else if (rise[1]) dx = -1;
      else if (rise[0]) dx = 1;
      if (rise != 4'b0000) begin
        nx = m_x + dx; ny = m_y + dy;
        if (nx < 0 || nx >= W || ny < 0 || ny >= H) m_bump = 1;
        else begin
          t_x = nx; t_y = ny; m_pend = 3;
        end
      end
    end
    m_prev = btn;
  endtask

  task automatic check_all();
    int exp_addr;
    exp_addr = (m_pend > 0) ? (t_y*W + t_x) : (m_y*W + m_x);
    check_eq("player_x", int'(player_x), m_x);
    check_eq("player_y", int'(player_y), m_y);
    check_eq("move_count", int'(move_count), m_cnt);
    check_eq("at_exit", int'(at_exit), int'(m_exit));
    check_eq("busy", int'(busy), int'(m_pend > 0));
    check_eq("maze_address", int'(maze_address), exp_addr);
`ifdef WALL_BUMP_EN
    check_eq("bump", int'(bump), int'(m_bump));
`endif
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_all();
  endtask

  task automatic set_btn(input bit [3:0] b);
    {btn_up, btn_down, btn_left, btn_right} = b;
  endtask

  // One-clock pulse on button(s) b ({up,down,left,right}), then let the move settle.
  task automatic press(input bit [3:0] b);
    set_btn(b);
    tick();
    set_btn(4'b0000);
    repeat (5) tick();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    tick();
    reset = 1'b0;
  endtask

  task automatic clear_maze();
    for (int i = 0; i < W*H; i++) maze[i] = 0;
  endtask

  initial begin
    reset   = 1'b1;
    gen_end = 1'b0;
    set_btn(4'b0000);
    clear_maze();
    model_reset();
    #1;
    check_all();
    @(negedge clock);

    // Basic move, wall at (1,1), off-grid rejections at the corner.
    maze[31] = 1;
    gen_end  = 1'b1;
    do_reset();
    tick();
    press(4'b0001);
    press(4'b0100);
    press(4'b0010);
    press(4'b1000);
    press(4'b0010);

    // Simultaneous up+right at (1,1) picks up; a left edge during the lookup is lost.
    maze[31] = 0;
    press(4'b0001);
    press(4'b0100);
    set_btn(4'b1001);
    tick();
    set_btn(4'b0000);
    tick();
    set_btn(4'b0010);
    tick();
    set_btn(4'b0000);
    repeat (5) tick();

    // Walk to the exit on an open maze, then confirm the position is frozen.
    clear_maze();
    do_reset();
    tick();
    for (int i = 0; i < EX; i++) press(4'b0001);
    for (int i = 0; i < EY; i++) press(4'b0100);
    press(4'b0010);
    press(4'b1000);

    // gen_end drop during WAIT discards the move and returns to start.
    press(4'b1000);
    gen_end = 1'b0;
    tick();
    gen_end = 1'b1;
    tick();
    press(4'b0001);
    set_btn(4'b0100);
    tick();
    set_btn(4'b0000);
    tick();
    gen_end = 1'b0;
    tick();
    gen_end = 1'b1;
    repeat (2) tick();

    // Asynchronous reset in the middle of a lookup.
    press(4'b0001);
    set_btn(4'b0001);
    tick();
    set_btn(4'b0000);
    do_reset();
    repeat (2) tick();

    // Random maze (row 0 floor) and random button levels with occasional gen_end drops.
    for (int i = 0; i < W*H; i++) maze[i] = (i >= W) && ($urandom_range(0, 99) < 30);
    for (int c = 0; c < 4000; c++) begin
      set_btn(4'($urandom_range(0, 15) & $urandom_range(0, 15)));
      if (!gen_end) gen_end = ($urandom_range(0, 3) == 0);
      else          gen_end = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
